// File: rtl/rr_arb_memory.sv
// Single-port scratch RAM shared by NUM_CH valid/ready requesters via a round-robin arbiter.
// One tagged response per accepted request, one cycle after acceptance.
module rr_arb_memory #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req_valid_i,
  input  logic [NUM_CH-1:0]            req_wr_rd_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_CH*WIDTH-1:0]      req_wdata_i,
  output logic [NUM_CH-1:0]            req_ready_o,
  output logic                         rsp_valid_o,
  output logic [CH_W-1:0]              rsp_ch_o,
  output logic                         rsp_wr_o,
  output logic [WIDTH-1:0]             rsp_data_o,
  output logic                         rsp_err_o
);
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
  } req_t;

  req_t [NUM_CH-1:0] req;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    assign req[c] = {req_wr_rd_i[c], req_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH],
                     req_wdata_i[c*WIDTH +: WIDTH]};
  end

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [CH_W-1:0]   ptr;
  logic [CH_W:0]     sum;
  logic [CH_W-1:0]   idx;
  logic [CH_W-1:0]   gnt_id;
  logic [NUM_CH-1:0] grant;
  logic              found;

  // Scan from ptr with an explicit wrap so NUM_CH need not be a power of two.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, ptr} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      idx = sum[CH_W-1:0];
      if (!found && !rst && req_valid_i[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        gnt_id      = idx;
      end
    end
  end

  assign req_ready_o = grant;

  req_t            sel;
  logic            in_range;
  logic [MW-1:0]   mem_idx;
  logic [CH_W-1:0] ptr_nxt;

  assign sel      = req[gnt_id];
  assign in_range = 32'(sel.addr) < DEPTH;
  assign mem_idx  = MW'(sel.addr);
  assign ptr_nxt  = (gnt_id == CH_W'(NUM_CH-1)) ? '0 : gnt_id + CH_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr         <= '0;
      rsp_valid_o <= 1'b0;
      rsp_ch_o    <= '0;
      rsp_wr_o    <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= found;
      rsp_err_o   <= found & ~in_range;
      if (found) begin
        ptr      <= ptr_nxt;
        rsp_ch_o <= gnt_id;
        rsp_wr_o <= sel.wr;
        if (sel.wr) begin
          if (in_range) mem[mem_idx] <= sel.wdata;
        end else begin
          // Out-of-range reads return zero rather than an aliased word.
          rsp_data_o <= in_range ? mem[mem_idx] : '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_rr_arb_memory.sv
// Directed bench for rr_arb_memory: a queue-free behavioural model checked every
// cycle, plus hand-computed literal expectations at key points of each scenario.
module tb_rr_arb_memory;
  localparam int W = 8, D = 16, AW = 5, N = 4, CW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_wdata;
  logic [AW-1:0]   a_arr [N];
  logic [W-1:0]    d_arr [N];

  logic [N-1:0]  req_ready;
  logic          rsp_valid, rsp_wr, rsp_err;
  logic [CW-1:0] rsp_ch;
  logic [W-1:0]  rsp_data;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int c = 0; c < N; c++) begin
      req_addr[c*AW +: AW] = a_arr[c];
      req_wdata[c*W +: W]  = d_arr[c];
    end
  end

  rr_arb_memory #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .NUM_CH(N), .CH_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_wr_rd_i(req_wr),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_ch_o(rsp_ch), .rsp_wr_o(rsp_wr),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the spec's rules in plain integers.
  int m_mem [D];
  int m_ptr, m_ch, m_data;
  bit m_valid, m_wr, m_err, m_live;

  function automatic int pick(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    if (rst) begin
      for (int i = 0; i < D; i++) m_mem[i] = 0;
      m_ptr = 0; m_valid = 0; m_ch = 0; m_wr = 0; m_data = 0; m_err = 0;
      m_live = 1;
    end else if (m_live) begin
      g = pick(m_ptr, req_valid);
      m_valid = (g >= 0);
      m_err   = 0;
      if (g >= 0) begin
        m_ch  = g;
        m_wr  = req_wr[g];
        m_err = (int'(a_arr[g]) >= D);
        if (req_wr[g]) begin
          if (!m_err) m_mem[a_arr[g]] = d_arr[g];
        end else begin
          m_data = m_err ? 0 : m_mem[a_arr[g]];
        end
        m_ptr = (g + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    if (m_live) begin
      g = pick(m_ptr, req_valid);
      chk("ready", 32'(req_ready), (rst || g < 0) ? 32'd0 : 32'(1) << g);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
      chk("rsp_ch", 32'(rsp_ch), 32'(m_ch));
      chk("rsp_wr", 32'(rsp_wr), 32'(m_wr));
      chk("rsp_data", 32'(rsp_data), 32'(m_data));
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int c, input logic wr, input int a, input int d);
    req_valid[c] = 1'b1;
    req_wr[c]    = wr;
    a_arr[c]     = AW'(a);
    d_arr[c]     = W'(d);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_wr = '0; m_live = 0;
    for (int c = 0; c < N; c++) begin a_arr[c] = '0; d_arr[c] = '0; end

    // 1: write then read-back through another channel; request held across reset
    set_req(1, 1'b1, 3, 8'hA5);
    tick; tick;
    @(negedge clk);
    chk("t1 ready in reset", 32'(req_ready), 32'd0);
    chk("t1 valid in reset", 32'(rsp_valid), 32'd0);
    chk("t1 data in reset", 32'(rsp_data), 32'd0);
    tick; rst = 1'b0;
    @(negedge clk);
    chk("t1 grant ch1", 32'(req_ready), 32'h2);
    tick; req_valid[1] = 1'b0; set_req(2, 1'b0, 3, 0);
    @(negedge clk);
    chk("t1 wr ack", {rsp_valid, rsp_wr, rsp_err, 6'd0, rsp_ch}, {1'b1, 1'b1, 1'b0, 6'd0, 2'd1});
    tick; req_valid[2] = 1'b0;
    @(negedge clk);
    chk("t1 rd data", 32'(rsp_data), 32'hA5);
    chk("t1 rd tag", {rsp_valid, rsp_wr, rsp_err, 6'd0, rsp_ch}, {1'b1, 1'b0, 1'b0, 6'd0, 2'd2});
    tick;
    @(negedge clk);
    chk("t1 idle", {rsp_valid, rsp_data}, {1'b0, 8'hA5});

    // 2: all channels valid from ptr=0
    rst = 1'b1; tick; rst = 1'b0;
    for (int c = 0; c < N; c++) set_req(c, 1'b0, c, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2 rr grant", 32'(req_ready), 32'(1) << (k % 4));
      if (k > 0) chk("t2 rsp_ch lag", 32'(rsp_ch), 32'((k - 1) % 4));
      tick;
    end
    req_valid = '0;

    // 3: ch3 alone three times, then ch0 wins after wrap
    set_req(3, 1'b0, 5, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3 ch3 grant", 32'(req_ready), 32'h8);
      tick;
    end
    set_req(0, 1'b0, 6, 0);
    @(negedge clk);
    chk("t3 ch0 after wrap", 32'(req_ready), 32'h1);
    tick; req_valid = '0;

    // 4: out-of-range write/read must not alias onto addr 4
    set_req(1, 1'b1, 4, 8'h77);
    tick; req_valid[1] = 1'b0; set_req(0, 1'b1, 20, 8'h3C);
    tick; set_req(0, 1'b0, 20, 0);
    @(negedge clk);
    chk("t4 oor wr", {rsp_valid, rsp_wr, rsp_err}, 3'b111);
    tick; set_req(0, 1'b0, 4, 0);
    @(negedge clk);
    chk("t4 oor rd", {rsp_valid, rsp_wr, rsp_err, rsp_data}, {3'b101, 8'h00});
    tick; req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t4 addr4 intact", {rsp_err, rsp_data}, {1'b0, 8'h77});

    // 5: reset right after a read accept; held requests re-arbitrate from ptr=0
    set_req(2, 1'b1, 3, 8'h5A);
    tick; set_req(2, 1'b0, 3, 0);
    tick; req_valid[2] = 1'b0; rst = 1'b1;
    set_req(1, 1'b0, 3, 0); set_req(3, 1'b0, 3, 0);
    @(negedge clk);
    chk("t5 rd before rst", {rsp_valid, rsp_data}, {1'b1, 8'h5A});
    chk("t5 ready in rst", 32'(req_ready), 32'd0);
    tick; rst = 1'b0;
    @(negedge clk);
    chk("t5 valid dropped", {rsp_valid, rsp_data}, {1'b0, 8'h00});
    chk("t5 ptr0 grant", 32'(req_ready), 32'h2);
    tick; req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t5 cleared mem", {rsp_valid, rsp_err, 6'd0, rsp_ch, rsp_data}, {2'b10, 6'd0, 2'd1, 8'h00});
    chk("t5 next ch3", 32'(req_ready), 32'h8);
    tick; req_valid[3] = 1'b0;
    @(negedge clk);
    chk("t5 ch3 rsp", {rsp_valid, 6'd0, rsp_ch, rsp_data}, {1'b1, 6'd0, 2'd3, 8'h00});
    tick; tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
